// File: rtl/hdd_sd_bridge.sv
// Sequences Apple II HDD block-transfer pulses onto the HPS virtual-disk handshake,
// stalling the CPU for the whole transfer and tracking mount/protect state.
module hdd_sd_bridge #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd14_318_180
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        soft_reset,
   input  logic        hdd_read,
   input  logic        hdd_write,
   input  logic        img_mounted,
   input  logic [63:0] img_size,
   input  logic        img_readonly,
   input  logic        sd_ack,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic        cpu_wait,
   output logic        hdd_mounted,
   output logic        hdd_protect,
   output logic        hdd_error
);

   // state | meaning
   // IDLE  | no transfer; serve pending read first, then pending write
   // REQ   | sd_rd/sd_wr raised, waiting for sd_ack rise
   // XFER  | HPS transferring, waiting for sd_ack fall
   typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

   state_t      state_q, state_d;
   logic        rd_pend, wr_pend, ack_d, op_wr;
   logic        sd_rd_q, sd_wr_q, cpu_wait_q, mounted_q, protect_q, error_q;
   logic        sd_rd_d, sd_wr_d, cpu_wait_d, error_d, clr_rd, clr_wr;
   logic        start_rd, start_wr, rej_rd, rej_wr, got_ack, done, timeout;
   logic [23:0] tmo;
   logic        rise, fall, tmo_last;

   assign rise     = sd_ack & ~ack_d;
   assign fall     = ~sd_ack & ack_d;
   assign tmo_last = (tmo == 24'd1);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)        state_q <= IDLE;
      else if (soft_reset) state_q <= IDLE;
      else                 state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      start_rd = 1'b0;
      start_wr = 1'b0;
      rej_rd   = 1'b0;
      rej_wr   = 1'b0;
      got_ack  = 1'b0;
      done     = 1'b0;
      timeout  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_pend && !mounted_q) begin
               rej_rd = 1'b1;
            end else if (rd_pend) begin
               start_rd = 1'b1;
               state_d  = REQ;
            end else if (wr_pend && (!mounted_q || protect_q)) begin
               rej_wr = 1'b1;
            end else if (wr_pend) begin
               start_wr = 1'b1;
               state_d  = REQ;
            end
         end
         REQ: begin
            if (tmo_last) begin
               timeout = 1'b1;
               state_d = IDLE;
            end else if (rise) begin
               got_ack = 1'b1;
               state_d = XFER;
            end
         end
         XFER: begin
            // a fall on the last budget cycle still counts as a completed transfer
            if (fall) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (tmo_last) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sd_rd_d    = sd_rd_q;
      sd_wr_d    = sd_wr_q;
      cpu_wait_d = cpu_wait_q;
      error_d    = error_q;
      clr_rd     = rej_rd | ((got_ack | timeout) & ~op_wr);
      clr_wr     = rej_wr | ((got_ack | timeout) & op_wr);
      if (start_rd || start_wr) begin
         sd_rd_d    = start_rd;
         sd_wr_d    = start_wr;
         cpu_wait_d = 1'b1;
         error_d    = 1'b0;
      end
      if (rej_rd || rej_wr) error_d = 1'b1;
      if (got_ack) begin
         sd_rd_d = 1'b0;
         sd_wr_d = 1'b0;
      end
      if (done) cpu_wait_d = 1'b0;
      if (timeout) begin
         sd_rd_d    = 1'b0;
         sd_wr_d    = 1'b0;
         cpu_wait_d = 1'b0;
         error_d    = 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend    <= 1'b0;
         wr_pend    <= 1'b0;
         ack_d      <= 1'b0;
         op_wr      <= 1'b0;
         sd_rd_q    <= 1'b0;
         sd_wr_q    <= 1'b0;
         cpu_wait_q <= 1'b0;
         mounted_q  <= 1'b0;
         protect_q  <= 1'b0;
         error_q    <= 1'b0;
         tmo        <= 24'd0;
      end else begin
         ack_d <= sd_ack;
         if (img_mounted) begin
            mounted_q <= |img_size;
            protect_q <= img_readonly;
         end
         if (soft_reset) begin
            rd_pend    <= 1'b0;
            wr_pend    <= 1'b0;
            op_wr      <= 1'b0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            cpu_wait_q <= 1'b0;
            error_q    <= 1'b0;
            tmo        <= 24'd0;
         end else begin
            // a new pulse wins over a same-cycle clear of its flag
            rd_pend    <= hdd_read | (rd_pend & ~clr_rd);
            wr_pend    <= hdd_write | (wr_pend & ~clr_wr);
            sd_rd_q    <= sd_rd_d;
            sd_wr_q    <= sd_wr_d;
            cpu_wait_q <= cpu_wait_d;
            error_q    <= error_d;
            if (start_rd || start_wr) begin
               tmo   <= TIMEOUT_CYCLES;
               op_wr <= start_wr;
            end else if (state_q != IDLE && tmo != 24'd0) begin
               tmo <= tmo - 24'd1;
            end
         end
      end
   end

   always_comb begin
      sd_rd       = sd_rd_q;
      sd_wr       = sd_wr_q;
      cpu_wait    = cpu_wait_q;
      hdd_mounted = mounted_q;
      hdd_protect = protect_q;
      hdd_error   = error_q;
   end

endmodule
